// File: rtl/fft_frame_deserializer.sv
// Word-serial to frame-parallel deserializer feeding the parallel FFT core.
// Complex (re/im interleaved) or real-only frames; valid/ready on both sides, one-frame skid.
module fft_frame_deserializer #(
   parameter int unsigned IN_W     = 16,
   parameter int unsigned N_POINTS = 8,
   parameter int unsigned CNT_W    = $clog2(2*N_POINTS)+1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         real_mode,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [IN_W-1:0]              in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [N_POINTS*2*IN_W-1:0]   out_data,
   output logic                         out_real,
   output logic                         mode_err
);

   localparam int unsigned SMP_W   = 2*IN_W;
   localparam int unsigned FRAME_W = N_POINTS*SMP_W;
   localparam int unsigned SIDX_W  = $clog2(N_POINTS);

   logic [CNT_W-1:0]   r_cnt;
   logic [FRAME_W-1:0] r_asm;
   logic               r_frame_mode;
   logic               r_in_ready;
   logic               r_mode_err;
   logic               r_out_valid;
   logic [FRAME_W-1:0] r_out_data;
   logic               r_out_real;

   logic               w_first;
   logic               w_acc;
   logic               w_mode;
   logic               w_last;
   logic               w_pend;
   logic               w_out_take;
   logic [SIDX_W-1:0]  w_sidx;
   logic [FRAME_W-1:0] w_asm_next;

   assign w_pend     = ~r_in_ready;
   assign w_first    = (r_cnt == '0);
   assign w_acc      = in_valid & r_in_ready;
   assign w_mode     = w_first ? real_mode : r_frame_mode;
   assign w_last     = w_acc & (w_mode ? (r_cnt == CNT_W'(N_POINTS-1))
                                       : (r_cnt == CNT_W'(2*N_POINTS-1)));
   assign w_out_take = r_out_valid & out_ready;
   assign w_sidx     = w_mode ? SIDX_W'(r_cnt) : SIDX_W'(r_cnt >> 1);

   // Assembly image with the current word merged; real frames zero the imag half of
   // each sample as its real word arrives, so no stale data survives between frames.
   always_comb begin
      w_asm_next = r_asm;
      for (int k = 0; k < int'(N_POINTS); k++) begin
         if (w_acc && (SIDX_W'(k) == w_sidx)) begin
            if (w_mode) begin
               w_asm_next[k*SMP_W+IN_W +: IN_W] = in_data;
               w_asm_next[k*SMP_W      +: IN_W] = '0;
            end else if (r_cnt[0]) begin
               w_asm_next[k*SMP_W      +: IN_W] = in_data;
            end else begin
               w_asm_next[k*SMP_W+IN_W +: IN_W] = in_data;
            end
         end
      end
   end

   // Input side: word counter, assembly register, frame mode latch, mode error pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt        <= '0;
         r_asm        <= '0;
         r_frame_mode <= 1'b0;
         r_mode_err   <= 1'b0;
      end else begin
         r_mode_err <= w_acc & ~w_first & (real_mode != r_frame_mode);
         if (w_acc) begin
            r_asm <= w_asm_next;
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
            if (w_first) begin
               r_frame_mode <= real_mode;
            end
         end
      end
   end

   // Output side: the assembly register doubles as the pending frame, since input
   // is stalled until the pending frame has moved to the output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_real  <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         if (w_pend && w_out_take) begin
            r_out_data  <= r_asm;
            r_out_real  <= r_frame_mode;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b1;
         end else if (w_last && (!r_out_valid || out_ready)) begin
            r_out_data  <= w_asm_next;
            r_out_real  <= w_mode;
            r_out_valid <= 1'b1;
         end else if (w_last) begin
            r_in_ready  <= 1'b0;
         end else if (w_out_take) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_real  = r_out_real;
   assign mode_err  = r_mode_err;

endmodule

// File: tb/tb_fft_frame_deserializer.sv
// Directed bench for fft_frame_deserializer: complex/real frames, backpressure,
// mode flip, asynchronous reset and gapped input.
module tb_fft_frame_deserializer;

   localparam int unsigned IN_W     = 16;
   localparam int unsigned N_POINTS = 8;
   localparam int unsigned FW       = N_POINTS*2*IN_W;

   logic            clk = 1'b0;
   logic            reset;
   logic            real_mode;
   logic            in_valid;
   logic            in_ready;
   logic [IN_W-1:0] in_data;
   logic            out_valid;
   logic            out_ready;
   logic [FW-1:0]   out_data;
   logic            out_real;
   logic            mode_err;

   int n_vec = 0;
   int n_err = 0;

   fft_frame_deserializer #(.IN_W(IN_W), .N_POINTS(N_POINTS)) dut (
      .clk(clk), .reset(reset), .real_mode(real_mode),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_real(out_real), .mode_err(mode_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply inputs, then advance to 1 time unit after the next rising edge.
   task automatic cycle(input logic v, input logic [IN_W-1:0] d, input logic rm, input logic ordy);
      in_valid  = v;
      in_data   = d;
      real_mode = rm;
      out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   // Complex frame of words base+1 .. base+16: sample k = {base+2k+1, base+2k+2}.
   function automatic logic [FW-1:0] exp_cplx(input logic [IN_W-1:0] base);
      logic [FW-1:0] r;
      r = '0;
      for (int k = 0; k < int'(N_POINTS); k++)
         r[k*2*IN_W +: 2*IN_W] = {base + IN_W'(2*k+1), base + IN_W'(2*k+2)};
      return r;
   endfunction

   // Real frame of words base+0 .. base+7: sample k = {base+k, 0}.
   function automatic logic [FW-1:0] exp_real(input logic [IN_W-1:0] base);
      logic [FW-1:0] r;
      r = '0;
      for (int k = 0; k < int'(N_POINTS); k++)
         r[k*2*IN_W +: 2*IN_W] = {base + IN_W'(k), 16'h0000};
      return r;
   endfunction

   initial begin
      reset = 1'b1; real_mode = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", FW'(out_valid), FW'(0));
      chk("rst_out_data",  out_data,       '0);
      chk("rst_out_real",  FW'(out_real),  FW'(0));
      chk("rst_mode_err",  FW'(mode_err),  FW'(0));
      chk("rst_in_ready",  FW'(in_ready),  FW'(1));
      reset = 1'b0;

      // Complex back-to-back
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b1, IN_W'(i), 1'b0, 1'b1);
         chk("cplx_in_ready", FW'(in_ready), FW'(1));
         if (i == 15) chk("cplx_valid_early", FW'(out_valid), FW'(0));
      end
      chk("cplx_out_valid", FW'(out_valid), FW'(1));
      chk("cplx_out_data",  out_data,       exp_cplx(16'h0000));
      chk("cplx_sample0",   FW'(out_data[31:0]),    FW'(32'h0001_0002));
      chk("cplx_sample7",   FW'(out_data[255:224]), FW'(32'h000F_0010));
      chk("cplx_out_real",  FW'(out_real),  FW'(0));
      cycle(1'b0, '0, 1'b0, 1'b1);
      chk("cplx_valid_one_cycle", FW'(out_valid), FW'(0));

      // Real mode
      for (int i = 0; i < 8; i++) cycle(1'b1, 16'hA000 + IN_W'(i), 1'b1, 1'b1);
      chk("real_out_valid", FW'(out_valid), FW'(1));
      chk("real_out_data",  out_data,       exp_real(16'hA000));
      chk("real_out_real",  FW'(out_real),  FW'(1));
      cycle(1'b0, '0, 1'b0, 1'b1);
      chk("real_valid_clear", FW'(out_valid), FW'(0));

      // Backpressure: two frames streamed with out_ready low
      for (int i = 1; i <= 32; i++) begin
         cycle(1'b1, (i <= 16) ? 16'h1100 + IN_W'(i) : 16'h2200 + IN_W'(i-16), 1'b0, 1'b0);
         if (i == 16) chk("bp_f1_data", out_data, exp_cplx(16'h1100));
         if (i == 31) chk("bp_in_ready_before", FW'(in_ready), FW'(1));
      end
      chk("bp_in_ready_pending", FW'(in_ready), FW'(0));
      chk("bp_f1_held",          out_data,      exp_cplx(16'h1100));
      cycle(1'b1, 16'hBEEF, 1'b0, 1'b0);
      chk("bp_f1_stable",  out_data,       exp_cplx(16'h1100));
      chk("bp_valid_held", FW'(out_valid), FW'(1));
      chk("bp_still_stall", FW'(in_ready), FW'(0));
      cycle(1'b0, '0, 1'b0, 1'b1);
      chk("bp_f2_data",     out_data,       exp_cplx(16'h2200));
      chk("bp_f2_valid",    FW'(out_valid), FW'(1));
      chk("bp_in_ready_up", FW'(in_ready),  FW'(1));
      cycle(1'b0, '0, 1'b0, 1'b1);
      chk("bp_valid_clear", FW'(out_valid), FW'(0));

      // Mid-frame mode flip on word 6 only
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b1, 16'h3000 + IN_W'(i), (i == 6), 1'b1);
         if (i == 5) chk("flip_err_w5", FW'(mode_err), FW'(0));
         if (i == 6) chk("flip_err_w6", FW'(mode_err), FW'(1));
         if (i == 7) chk("flip_err_w7", FW'(mode_err), FW'(0));
         if (i == 15) chk("flip_valid_early", FW'(out_valid), FW'(0));
      end
      chk("flip_out_valid", FW'(out_valid), FW'(1));
      chk("flip_out_real",  FW'(out_real),  FW'(0));
      chk("flip_out_data",  out_data,       exp_cplx(16'h3000));
      cycle(1'b0, '0, 1'b0, 1'b1);

      // Asynchronous reset mid-frame with a frame on the output
      for (int i = 1; i <= 21; i++) cycle(1'b1, 16'h5000 + IN_W'(i), 1'b0, 1'b0);
      chk("rst2_pre_valid", FW'(out_valid), FW'(1));
      in_valid = 1'b0;
      reset = 1'b1;
      #2;
      chk("rst2_out_valid", FW'(out_valid), FW'(0));
      chk("rst2_out_data",  out_data,       '0);
      chk("rst2_out_real",  FW'(out_real),  FW'(0));
      chk("rst2_mode_err",  FW'(mode_err),  FW'(0));
      chk("rst2_in_ready",  FW'(in_ready),  FW'(1));
      reset = 1'b0;
      for (int i = 1; i <= 16; i++) cycle(1'b1, 16'h4000 + IN_W'(i), 1'b0, 1'b1);
      chk("rst2_frame_valid", FW'(out_valid), FW'(1));
      chk("rst2_frame_data",  out_data,       exp_cplx(16'h4000));
      cycle(1'b0, '0, 1'b0, 1'b1);

      // Gapped input: valid toggling every cycle, junk on idle cycles
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b1, IN_W'(i), 1'b0, 1'b1);
         if (i == 16) break;
         cycle(1'b0, 16'hDEAD, 1'b1, 1'b1);
         if (i == 15) chk("gap_valid_early", FW'(out_valid), FW'(0));
      end
      chk("gap_out_valid", FW'(out_valid), FW'(1));
      chk("gap_out_data",  out_data,       exp_cplx(16'h0000));
      chk("gap_mode_err",  FW'(mode_err),  FW'(0));
      cycle(1'b0, '0, 1'b0, 1'b1);
      chk("gap_valid_clear", FW'(out_valid), FW'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
